// File: rtl/elevator_call_panel.sv
// rtl/elevator_call_panel.sv - synchronise, debounce and latch car-panel calls for the elevator controller
module elevator_call_panel #(
    parameter int NFLOORS    = 8,
    parameter int FLOOR_W    = 3,
    parameter int DEB_CYCLES = 4,
    parameter int OPEN_HOLD  = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NFLOORS-1:0] btn,
    input  logic               btn_open,
    input  logic               btn_close,
    input  logic               open,
    input  logic               close,
    input  logic               up,
    input  logic               down,
    input  logic [FLOOR_W-1:0] y,
    output logic [NFLOORS-1:0] req,
    output logic [NFLOORS-1:0] lamp,
    output logic               door_open_req,
    output logic               door_close_req,
    output logic [3:0]         pending_cnt
);

    localparam int NIN = NFLOORS + 2;
    localparam int CW  = 4;
    localparam int HW  = $clog2(OPEN_HOLD + 1);

    logic [NIN-1:0]     raw, sync1, sync2, deb, deb_q, press;
    logic [CW-1:0]      cnt [NIN];
    logic [HW-1:0]      hold, hold_nxt;
    logic [NFLOORS-1:0] served, req_nxt;
    logic [3:0]         cnt_nxt;
    logic               open_ev, close_ev, moving;
    logic               dopen_nxt, dclose_nxt;

    // Door buttons ride along with the floor buttons through the same debouncer.
    assign raw      = {btn_close, btn_open, btn};
    assign press    = deb & ~deb_q;
    assign open_ev  = press[NFLOORS];
    assign close_ev = press[NFLOORS+1];
    assign moving   = up | down;
    assign lamp     = req;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
            deb   <= '0;
            deb_q <= '0;
            for (int i = 0; i < NIN; i++) cnt[i] <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            deb_q <= deb;
            for (int i = 0; i < NIN; i++) begin
                if (sync2[i] == deb[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CW'(DEB_CYCLES - 1)) begin
                    deb[i] <= ~deb[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    // A floor being served both clears its request and swallows a same-cycle press.
    always_comb begin
        cnt_nxt = '0;
        for (int i = 0; i < NFLOORS; i++) begin
            served[i] = open && (y == FLOOR_W'(i));
        end
        req_nxt = (req | press[NFLOORS-1:0]) & ~served;
        for (int i = 0; i < NFLOORS; i++) begin
            cnt_nxt = cnt_nxt + {3'b000, req_nxt[i]};
        end
    end

    always_comb begin
        dopen_nxt  = door_open_req;
        hold_nxt   = hold;
        dclose_nxt = door_close_req;
        if (open || moving) begin
            dopen_nxt = 1'b0;
            hold_nxt  = '0;
        end else if (open_ev) begin
            dopen_nxt = 1'b1;
            hold_nxt  = HW'(OPEN_HOLD);
        end else if (door_open_req) begin
            if (hold == HW'(1)) dopen_nxt = 1'b0;
            hold_nxt = hold - 1'b1;
        end
        if (close || open_ev) begin
            dclose_nxt = 1'b0;
        end else if (close_ev) begin
            dclose_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            req            <= '0;
            pending_cnt    <= '0;
            door_open_req  <= 1'b0;
            door_close_req <= 1'b0;
            hold           <= '0;
        end else begin
            req            <= req_nxt;
            pending_cnt    <= cnt_nxt;
            door_open_req  <= dopen_nxt;
            door_close_req <= dclose_nxt;
            hold           <= hold_nxt;
        end
    end

endmodule

// File: tb/tb_elevator_call_panel.sv
// tb/tb_elevator_call_panel.sv - scoreboard bench for elevator_call_panel
module tb_elevator_call_panel;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] btn = '0;
    logic       btn_open = 1'b0, btn_close = 1'b0;
    logic       open = 1'b0, close = 1'b0, up = 1'b0, down = 1'b0;
    logic [2:0] y = '0;
    logic [7:0] req, lamp;
    logic       door_open_req, door_close_req;
    logic [3:0] pending_cnt;

    int total = 0;
    int bad   = 0;
    logic [21:0] q[$];
    logic [21:0] e, obs;

    elevator_call_panel dut (
        .clk(clk), .rst(rst), .btn(btn), .btn_open(btn_open), .btn_close(btn_close),
        .open(open), .close(close), .up(up), .down(down), .y(y),
        .req(req), .lamp(lamp), .door_open_req(door_open_req),
        .door_close_req(door_close_req), .pending_cnt(pending_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [21:0] ex(input logic [7:0] r, input logic o, input logic c,
                                       input logic [3:0] n);
        return {r, r, o, c, n};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        btn = 8'hA5;
        repeat (3) q.push_back(ex(8'h00, 1'b0, 1'b0, 4'd0));
        for (int i = 0; q.size() > 0; i++) begin
            step();
            e = q.pop_front();
            obs = {req, lamp, door_open_req, door_close_req, pending_cnt};
            total++;
            if (obs !== e) begin
                bad++;
                $display("FAIL reset cyc%0d got=%h want=%h", i, obs, e);
            end
        end
        btn = '0;
        rst = 1'b0;
    endtask

    task automatic test_latency();
        do_reset();
        btn = 8'h08;
        repeat (6) q.push_back(ex(8'h00, 1'b0, 1'b0, 4'd0));
        repeat (4) q.push_back(ex(8'h08, 1'b0, 1'b0, 4'd1));
        for (int i = 0; q.size() > 0; i++) begin
            step();
            e = q.pop_front();
            obs = {req, lamp, door_open_req, door_close_req, pending_cnt};
            total++;
            if (obs !== e) begin
                bad++;
                $display("FAIL latency edge%0d got=%h want=%h", i + 1, obs, e);
            end
        end
        btn = '0;
    endtask

    task automatic test_glitch();
        do_reset();
        btn = 8'h20;
        repeat (12) q.push_back(ex(8'h00, 1'b0, 1'b0, 4'd0));
        for (int i = 0; q.size() > 0; i++) begin
            if (i == 3) btn = '0;
            step();
            e = q.pop_front();
            obs = {req, lamp, door_open_req, door_close_req, pending_cnt};
            total++;
            if (obs !== e) begin
                bad++;
                $display("FAIL glitch edge%0d got=%h want=%h", i + 1, obs, e);
            end
        end
    endtask

    task automatic test_serve();
        do_reset();
        btn = 8'h28;
        repeat (6)  q.push_back(ex(8'h00, 1'b0, 1'b0, 4'd0));
        repeat (4)  q.push_back(ex(8'h28, 1'b0, 1'b0, 4'd2));
        q.push_back(ex(8'h08, 1'b0, 1'b0, 4'd1));
        repeat (14) q.push_back(ex(8'h00, 1'b0, 1'b0, 4'd0));
        for (int i = 0; q.size() > 0; i++) begin
            if (i == 7) btn = '0;
            if (i == 10) begin open = 1'b1; y = 3'd5; end
            if (i == 11) begin y = 3'd3; btn = 8'h08; end
            if (i == 22) begin open = 1'b0; btn = '0; end
            step();
            e = q.pop_front();
            obs = {req, lamp, door_open_req, door_close_req, pending_cnt};
            total++;
            if (obs !== e) begin
                bad++;
                $display("FAIL serve edge%0d got=%h want=%h", i + 1, obs, e);
            end
        end
    endtask

    task automatic test_door_open();
        do_reset();
        up = 1'b1;
        btn_open = 1'b1;
        repeat (24) q.push_back(ex(8'h00, 1'b0, 1'b0, 4'd0));
        repeat (16) q.push_back(ex(8'h00, 1'b1, 1'b0, 4'd0));
        repeat (3)  q.push_back(ex(8'h00, 1'b0, 1'b0, 4'd0));
        for (int i = 0; q.size() > 0; i++) begin
            if (i == 10) btn_open = 1'b0;
            if (i == 18) begin up = 1'b0; btn_open = 1'b1; end
            step();
            e = q.pop_front();
            obs = {req, lamp, door_open_req, door_close_req, pending_cnt};
            total++;
            if (obs !== e) begin
                bad++;
                $display("FAIL door_open edge%0d got=%h want=%h", i + 1, obs, e);
            end
        end
        btn_open = 1'b0;
    endtask

    task automatic test_both_doors();
        rst = 1'b1;
        btn_open = 1'b1;
        btn_close = 1'b1;
        step();
        rst = 1'b0;
        repeat (6)  q.push_back(ex(8'h00, 1'b0, 1'b0, 4'd0));
        repeat (16) q.push_back(ex(8'h00, 1'b1, 1'b0, 4'd0));
        repeat (9)  q.push_back(ex(8'h00, 1'b0, 1'b0, 4'd0));
        repeat (4)  q.push_back(ex(8'h00, 1'b0, 1'b1, 4'd0));
        repeat (3)  q.push_back(ex(8'h00, 1'b0, 1'b0, 4'd0));
        for (int i = 0; q.size() > 0; i++) begin
            if (i == 7) begin btn_open = 1'b0; btn_close = 1'b0; end
            if (i == 25) btn_close = 1'b1;
            if (i == 35) close = 1'b1;
            if (i == 36) begin close = 1'b0; btn_close = 1'b0; end
            step();
            e = q.pop_front();
            obs = {req, lamp, door_open_req, door_close_req, pending_cnt};
            total++;
            if (obs !== e) begin
                bad++;
                $display("FAIL both_doors edge%0d got=%h want=%h", i + 1, obs, e);
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        btn = 8'hFF;
        repeat (10) q.push_back(ex(8'h00, 1'b0, 1'b0, 4'd0));
        q.push_back(ex(8'hFF, 1'b0, 1'b0, 4'd8));
        repeat (11) q.push_back(ex(8'h00, 1'b0, 1'b0, 4'd0));
        for (int i = 0; q.size() > 0; i++) begin
            if (i == 3 || i == 11) rst = 1'b1;
            if (i == 4) rst = 1'b0;
            if (i == 12) begin rst = 1'b0; btn = '0; end
            step();
            e = q.pop_front();
            obs = {req, lamp, door_open_req, door_close_req, pending_cnt};
            total++;
            if (obs !== e) begin
                bad++;
                $display("FAIL reset_mid edge%0d got=%h want=%h", i + 1, obs, e);
            end
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_latency();
        test_glitch();
        test_serve();
        test_door_open();
        test_both_doors();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/elevator_call_panel.md
Name: elevator_call_panel

Overview:
- Front end of the elevator controller: turns raw car-panel buttons into the request levels the controller consumes (inG..in7, inopen, inclose), and clears each request when the controller reports service.
- Synchronises, debounces and latches floor calls, drives call lamps, and arbitrates door open/close requests against car motion.
- Sits between the physical panel and the elevator controller. Its outputs feed the controller's floor/door inputs. The controller's open/close/up/down/y outputs feed back into this block.

Parameters:
- NFLOORS, 8, number of floors; bit 0 = ground (G), bit 7 = F7
- FLOOR_W, 3, width of floor index y
- DEB_CYCLES, 4, consecutive stable synchronised cycles required to accept a press or a release (1..15)
- OPEN_HOLD, 16, maximum cycles a latched door-open request stays asserted without being served (1..255)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- btn  in  NFLOORS  raw floor buttons, asynchronous, active-high
- btn_open  in  1  raw door-open button, asynchronous
- btn_close  in  1  raw door-close button, asynchronous
- open  in  1  controller door-open state indication
- close  in  1  controller door-close state indication
- up  in  1  controller moving-up indication
- down  in  1  controller moving-down indication
- y  in  FLOOR_W  controller current floor
- req  out  NFLOORS  latched floor requests to controller (bit i -> in_i)
- lamp  out  NFLOORS  call lamps
- door_open_req  out  1  to controller inopen
- door_close_req  out  1  to controller inclose
- pending_cnt  out  4  number of set bits in req

Behaviour:
- All state is updated on the rising edge of clk. rst is synchronous and active-high; reset takes priority over every other event.
- Reset values: req=0, lamp=0, door_open_req=0, door_close_req=0, pending_cnt=0. Synchroniser flops, debounce counters, debounced levels and the hold counter are all cleared.
- Synchroniser: each raw input (NFLOORS+2 of them) passes through two flops.
- Debounce, per input:
  - A saturating counter increments while the synchronised level differs from the debounced level, and resets to 0 when they match.
  - When the counter reaches DEB_CYCLES, the debounced level toggles and the counter clears.
  - A press event is the rising edge of the debounced level; it lasts one cycle.
- Latency: raw high held steady gives an accepted press event after DEB_CYCLES+2 edges. The resulting req/door output is visible after DEB_CYCLES+3 edges (7 with default).
- Pulses shorter than DEB_CYCLES synchronised cycles produce no event.
- Floor request i:
  - Served condition: open==1 && y==i.
  - Set on press event i unless the served condition holds in the same cycle (press discarded).
  - Cleared when the served condition holds; clear beats set.
  - Stays set across any number of further presses.
- lamp equals req (same register, no extra latency).
- pending_cnt is the registered popcount of the next req value, so it changes in the same cycle as req. Range 0..8.
- Door-open request:
  - Press event with up==0 && down==0 sets door_open_req and loads the hold counter with OPEN_HOLD.
  - A press while up or down is asserted is discarded.
  - Cleared when open==1, when the hold counter reaches 0 (decrements each cycle while set), or when up/down asserts.
  - A new press while already set reloads the counter.
- Door-close request:
  - Press event sets door_close_req; cleared when close==1 or on a door-open press event.
  - If open and close press events occur in the same cycle, the open event wins: door_open_req is set and door_close_req is cleared/not set.
- Multiple floor press events in one cycle are all latched.
- No combinational path from any input to any output.

Test Plan:
- Reset then hold btn[3]=1 steady -> req=8'h08, lamp=8'h08, pending_cnt=1 exactly 7 edges after assertion; all outputs 0 before that.
- btn[5] high for 3 cycles only (DEB_CYCLES=4) -> req stays 0, pending_cnt 0.
- req=8'h28 latched; drive open=1, y=5 for one cycle -> req=8'h08, pending_cnt=1 next edge. Then press btn[3] while open=1, y=3 -> req=0, press discarded.
- btn_open pressed with up=1 -> door_open_req stays 0. Pressed with up=down=0 and open never asserted -> door_open_req high for exactly 16 cycles, then 0.
- btn_open and btn_close released from reset simultaneously stable -> door_open_req=1, door_close_req=0. Later close press -> door_close_req=1 until close=1 is sampled, then 0 next edge.
- All 8 floor buttons pressed together, then rst=1 for one cycle mid-debounce and again after latching -> all outputs 0 the edge after rst; no stale press is accepted after rst deasserts unless buttons are held a full DEB_CYCLES+2 more edges.
